// File: rtl/leaf_pkt_pkg.sv
// leaf_pkt_pkg: 49-bit BFT packet layout and pack/unpack helpers,
// shared by leaf-side RTL, this injector and benches.
package leaf_pkt_pkg;
    localparam int PKT_W     = 49;
    localparam int PAYLOAD_W = 32;
    localparam int LEAF_W    = 5;
    localparam int PORT_W    = 4;
    localparam int ADDR_W    = 7;
    localparam int VALID_BIT = 48;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_LSB  = 32;
    localparam logic [PORT_W-1:0] CTRL_PORT = '0;

    typedef struct packed {
        logic                 valid;
        logic [LEAF_W-1:0]    leaf;
        logic [PORT_W-1:0]    port;
        logic [ADDR_W-1:0]    addr;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

    function automatic logic [PKT_W-1:0] pack_pkt(
        input logic [LEAF_W-1:0]    leaf,
        input logic [PORT_W-1:0]    port,
        input logic [ADDR_W-1:0]    addr,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [PKT_W-1:0] w;
        w = '0;
        w[VALID_BIT]               = 1'b1;
        w[LEAF_LSB +: LEAF_W]      = leaf;
        w[PORT_LSB +: PORT_W]      = port;
        w[ADDR_LSB +: ADDR_W]      = addr;
        w[PAYLOAD_W-1:0]           = payload;
        return w;
    endfunction

    function automatic pkt_t unpack_pkt(input logic [PKT_W-1:0] w);
        pkt_t p;
        p.valid   = w[VALID_BIT];
        p.leaf    = w[LEAF_LSB +: LEAF_W];
        p.port    = w[PORT_LSB +: PORT_W];
        p.addr    = w[ADDR_LSB +: ADDR_W];
        p.payload = w[PAYLOAD_W-1:0];
        return p;
    endfunction
endpackage

// File: rtl/leaf_stream_injector_credit_counter.sv
// leaf_credit_counter: per-port send credits, -1 per send, +amount per return,
// saturating at CREDIT_INIT with a one-cycle overflow flag.
module leaf_credit_counter #(
    parameter int CREDIT_INIT = 128,
    parameter int CW          = $clog2(CREDIT_INIT) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          dec_i,
    input  logic          inc_i,
    input  logic [CW-1:0] amount_i,
    output logic [CW-1:0] credit_o,
    output logic          nonzero_o,
    output logic          overflow_o
);
    logic [CW-1:0] credit_q, credit_d;
    logic [CW:0]   sum;

    // One extra bit so a return on a nearly full port cannot wrap before the compare.
    assign sum        = {1'b0, credit_q} + (inc_i ? {1'b0, amount_i} : '0) - {{CW{1'b0}}, dec_i};
    assign overflow_o = sum > (CW+1)'(CREDIT_INIT);
    assign credit_d   = overflow_o ? CW'(CREDIT_INIT) : sum[CW-1:0];
    assign credit_o   = credit_q;
    assign nonzero_o  = |credit_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) credit_q <= CW'(CREDIT_INIT);
        else         credit_q <= credit_d;
    end
endmodule

// File: rtl/leaf_stream_injector.sv
// leaf_stream_injector: round-robin packs NUM_PORTS word streams into BFT packets
// under per-port credits, and decodes leaf packets into data words and credit returns.
module leaf_stream_injector
    import leaf_pkt_pkg::*;
#(
    parameter int NUM_PORTS             = 3,
    parameter int CREDIT_INIT           = 128,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                          clk_400,
    input  logic                          reset_400_n,
    input  logic [LEAF_W-1:0]             dest_leaf,
    input  logic [NUM_PORTS*PAYLOAD_W-1:0] din_user,
    input  logic [NUM_PORTS-1:0]          vld_user,
    output logic [NUM_PORTS-1:0]          ack_user,
    output logic [PKT_W-1:0]              dout_pkt2leaf,
    input  logic [PKT_W-1:0]              din_pkt_leaf2host,
    output logic [PAYLOAD_W-1:0]          dout_rx,
    output logic [PORT_W-1:0]             port_rx,
    output logic                          vld_rx,
    input  logic                          resend,
    output logic                          credit_err
);
    localparam int CW = $clog2(CREDIT_INIT) + 1;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    pkt_t                          rx_pkt;
    logic [NUM_PORTS-1:0]          elig, grant, inc, nonzero, overflow;
    logic [NUM_PORTS-1:0][CW-1:0]  credit;
    logic [PW-1:0]                 win, ptr_q, ptr_d;
    logic                          found, ctrl_rx, data_rx, bad_ret, unused_bits;
    logic [PORT_W-1:0]             ret_port;
    logic [ADDR_W-1:0]             addr_q [NUM_PORTS];
    logic [PKT_W-1:0]              tx_q, tx_d;
    logic [PAYLOAD_W-1:0]          dout_rx_q;
    logic [PORT_W-1:0]             port_rx_q;
    logic                          vld_rx_q, credit_err_q;

    assign rx_pkt   = unpack_pkt(din_pkt_leaf2host);
    assign ctrl_rx  = rx_pkt.valid && rx_pkt.port == CTRL_PORT;
    assign data_rx  = rx_pkt.valid && rx_pkt.port != CTRL_PORT;
    assign ret_port = rx_pkt.payload[PORT_W-1:0];
    assign bad_ret  = ctrl_rx && (ret_port == '0 || ret_port > PORT_W'(NUM_PORTS));
    assign unused_bits = ^{credit, rx_pkt.leaf, rx_pkt.addr};

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        assign elig[k] = vld_user[k] && nonzero[k] && !resend;
        assign inc[k]  = ctrl_rx && ret_port == PORT_W'(k + 1);
        leaf_credit_counter #(.CREDIT_INIT(CREDIT_INIT), .CW(CW)) u_cnt (
            .clk_i      (clk_400),
            .rst_ni     (reset_400_n),
            .dec_i      (grant[k]),
            .inc_i      (inc[k]),
            .amount_i   (CW'(FREESPACE_UPDATE_SIZE)),
            .credit_o   (credit[k]),
            .nonzero_o  (nonzero[k]),
            .overflow_o (overflow[k])
        );
    end

    // First eligible stream at or after the pointer wins.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && elig[(int'(ptr_q) + i) % NUM_PORTS]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + i) % NUM_PORTS);
            end
        end
        if (found) grant[win] = 1'b1;
        ptr_d = !found ? ptr_q : (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
        tx_d  = found ? pack_pkt(dest_leaf, PORT_W'(win) + PORT_W'(1), addr_q[win],
                                 din_user[int'(win)*PAYLOAD_W +: PAYLOAD_W]) : '0;
    end

    always_ff @(posedge clk_400 or negedge reset_400_n) begin
        if (!reset_400_n) begin
            ptr_q        <= '0;
            tx_q         <= '0;
            addr_q       <= '{default: '0};
            dout_rx_q    <= '0;
            port_rx_q    <= '0;
            vld_rx_q     <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            tx_q  <= tx_d;
            for (int i = 0; i < NUM_PORTS; i++)
                if (grant[i]) addr_q[i] <= addr_q[i] + 1'b1;
            vld_rx_q <= data_rx;
            if (data_rx) begin
                dout_rx_q <= rx_pkt.payload;
                port_rx_q <= rx_pkt.port;
            end
            credit_err_q <= credit_err_q || |overflow || bad_ret;
        end
    end

    assign ack_user      = grant;
    assign dout_pkt2leaf = resend ? '0 : tx_q;
    assign dout_rx       = dout_rx_q;
    assign port_rx       = port_rx_q;
    assign vld_rx        = vld_rx_q;
    assign credit_err    = credit_err_q;
endmodule

// File: tb/tb_leaf_stream_injector.sv
// tb_leaf_stream_injector: directed steps with a packet/RX scoreboard and a
// behavioural credit/round-robin model.
module tb_leaf_stream_injector;
    localparam int N = 3;

    logic          clk_400 = 1'b0;
    logic          reset_400_n = 1'b0;
    logic [4:0]    dest_leaf = '0;
    logic [N*32-1:0] din_user = '0;
    logic [N-1:0]  vld_user = '0;
    logic [N-1:0]  ack_user;
    logic [48:0]   dout_pkt2leaf;
    logic [48:0]   din_pkt_leaf2host = '0;
    logic [31:0]   dout_rx;
    logic [3:0]    port_rx;
    logic          vld_rx;
    logic          resend = 1'b0;
    logic          credit_err;

    int            checks = 0;
    int            errors = 0;
    logic [48:0]   pkt_q[$];
    logic [36:0]   rx_q[$];
    int            m_credit[N];
    int            m_addr[N];
    int            m_ptr;
    logic          m_err;
    logic [N-1:0]  last_ack;
    int            n;

    always #5 clk_400 = ~clk_400;

    leaf_stream_injector dut (
        .clk_400           (clk_400),
        .reset_400_n       (reset_400_n),
        .dest_leaf         (dest_leaf),
        .din_user          (din_user),
        .vld_user          (vld_user),
        .ack_user          (ack_user),
        .dout_pkt2leaf     (dout_pkt2leaf),
        .din_pkt_leaf2host (din_pkt_leaf2host),
        .dout_rx           (dout_rx),
        .port_rx           (port_rx),
        .vld_rx            (vld_rx),
        .resend            (resend),
        .credit_err        (credit_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_400_n = 1'b0;
        vld_user = '0;
        resend = 1'b0;
        din_pkt_leaf2host = '0;
        din_user = '0;
        repeat (2) @(posedge clk_400);
        #1;
        chk("rst_pkt", dout_pkt2leaf, 0);
        chk("rst_ack", ack_user, 0);
        chk("rst_vld_rx", vld_rx, 0);
        chk("rst_dout_rx", dout_rx, 0);
        chk("rst_port_rx", port_rx, 0);
        chk("rst_err", credit_err, 0);
        reset_400_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_credit[i] = 128;
            m_addr[i] = 0;
        end
        m_ptr = 0;
        m_err = 1'b0;
        pkt_q.delete();
        rx_q.delete();
        pkt_q.push_back('0);
        rx_q.push_back('0);
    endtask

    // One clock: check last cycle's results, predict this cycle, advance past the edge.
    task automatic cycle();
        int g;
        int c;
        logic [48:0] p;
        logic [36:0] r;
        logic [N-1:0] ea;
        logic [3:0] t;
        @(negedge clk_400);
        p = pkt_q.pop_front();
        chk("pkt", dout_pkt2leaf, resend ? 49'd0 : p);
        r = rx_q.pop_front();
        chk("rx_vld", vld_rx, r[36]);
        if (r[36]) begin
            chk("rx_port", port_rx, r[35:32]);
            chk("rx_data", dout_rx, r[31:0]);
        end
        chk("credit_err", credit_err, m_err);
        g = -1;
        if (!resend)
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (g < 0 && vld_user[k] && m_credit[k] > 0) g = k;
            end
        ea = '0;
        if (g >= 0) ea[g] = 1'b1;
        chk("ack", ack_user, ea);
        last_ack = ack_user;
        if (g >= 0) begin
            pkt_q.push_back({1'b1, dest_leaf, 4'(g + 1), 7'(m_addr[g]), din_user[g*32 +: 32]});
            m_credit[g]--;
            m_addr[g] = (m_addr[g] + 1) % 128;
            m_ptr = (g + 1) % N;
        end else pkt_q.push_back('0);
        r = '0;
        if (din_pkt_leaf2host[48]) begin
            if (din_pkt_leaf2host[42:39] == 4'd0) begin
                t = din_pkt_leaf2host[3:0];
                if (t >= 1 && t <= N) begin
                    c = m_credit[t-1] + 64;
                    if (c > 128) begin
                        c = 128;
                        m_err = 1'b1;
                    end
                    m_credit[t-1] = c;
                end else m_err = 1'b1;
            end else r = {1'b1, din_pkt_leaf2host[42:39], din_pkt_leaf2host[31:0]};
        end
        rx_q.push_back(r);
        @(posedge clk_400);
        #1;
    endtask

    initial begin
        // single stream after reset
        do_reset();
        dest_leaf = 5'd3;
        din_user[31:0] = 32'hA5A5_0001;
        vld_user = 3'b001;
        cycle();
        chk("t1_ack", last_ack, 3'b001);
        vld_user = '0;
        chk("t1_pkt", dout_pkt2leaf, {1'b1, 5'd3, 4'd1, 7'd0, 32'hA5A5_0001});
        cycle();

        // round-robin rotation with all streams valid
        do_reset();
        dest_leaf = 5'd17;
        vld_user = 3'b111;
        for (int i = 0; i < 6; i++) begin
            din_user = {32'(32'hC200_0000 + i), 32'(32'hC100_0000 + i), 32'(32'hC000_0000 + i)};
            cycle();
            chk($sformatf("t2_ack%0d", i), last_ack, 3'b001 << (i % 3));
        end
        vld_user = 3'b001;
        cycle();
        chk("t2_addr", dout_pkt2leaf[38:32], 7'd2);
        vld_user = '0;
        cycle();

        // credit exhaustion and recovery on port 1
        do_reset();
        vld_user = 3'b001;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            din_user[31:0] = 32'(i);
            cycle();
            if (last_ack[0]) n++;
            else break;
        end
        chk("t3_sent", n, 128);
        chk("t3_blocked", last_ack, 0);
        din_pkt_leaf2host = {1'b1, 5'd0, 4'd0, 7'd0, 32'd1};
        cycle();
        chk("t3_inject_cycle", last_ack, 0);
        din_pkt_leaf2host = '0;
        cycle();
        chk("t3_resume", last_ack, 3'b001);
        vld_user = '0;
        cycle();

        // simultaneous send and return from credit 10 leaves 73
        do_reset();
        vld_user = 3'b001;
        repeat (118) cycle();
        din_pkt_leaf2host = {1'b1, 5'd9, 4'd0, 7'd5, 32'd1};
        cycle();
        chk("t4_ack", last_ack, 3'b001);
        din_pkt_leaf2host = '0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (last_ack[0]) n++;
            else break;
        end
        chk("t4_credit", n, 73);
        vld_user = '0;
        cycle();

        // bad return port, then return on a full port
        do_reset();
        din_pkt_leaf2host = {1'b1, 5'd0, 4'd0, 7'd0, 32'd5};
        cycle();
        din_pkt_leaf2host = '0;
        cycle();
        chk("t5_err_bad", credit_err, 1);
        repeat (3) cycle();
        chk("t5_err_sticky", credit_err, 1);
        do_reset();
        din_pkt_leaf2host = {1'b1, 5'd0, 4'd0, 7'd0, 32'd2};
        cycle();
        din_pkt_leaf2host = '0;
        cycle();
        chk("t5_err_full", credit_err, 1);
        vld_user = 3'b010;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (last_ack[1]) n++;
            else break;
        end
        chk("t5_credit_kept", n, 128);
        vld_user = '0;
        cycle();

        // data packet decode
        do_reset();
        din_pkt_leaf2host = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEAD_BEEF};
        cycle();
        din_pkt_leaf2host = '0;
        chk("t6_vld_rx", vld_rx, 1);
        chk("t6_port_rx", port_rx, 4'd2);
        chk("t6_dout_rx", dout_rx, 32'hDEAD_BEEF);
        cycle();
        chk("t6_vld_rx_drop", vld_rx, 0);

        // resend holds output and grants
        do_reset();
        din_user = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        vld_user = 3'b111;
        cycle();
        chk("t7_first", last_ack, 3'b001);
        resend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("t7_noack%0d", i), last_ack, 0);
            chk($sformatf("t7_idle%0d", i), dout_pkt2leaf, 0);
        end
        resend = 1'b0;
        cycle();
        chk("t7_resume", last_ack, 3'b010);
        vld_user = '0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
